// File: rtl/fsm_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_dispatch
//  Purpose  : Routes tagged bytes from the input FIFO to the varint or raw FIFO,
//             stamping each byte with a per-field index. Optional statistics
//             counters are enabled by defining FSM_DISPATCH_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module fsm_dispatch #(
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_fifo_empty,
    input  logic [DATA_W+1:0]  in_fifo_q,
    output logic               in_fifo_pop,
    input  logic               varint_fifo_full,
    output logic               varint_fifo_clr,
    output logic               varint_fifo_push,
    output logic [INDEX_W-1:0] varint_index_d,
    output logic [DATA_W-1:0]  varint_data_d,
    input  logic               raw_data_fifo_full,
    output logic               raw_data_fifo_clr,
    output logic               raw_data_fifo_push,
    output logic [INDEX_W-1:0] raw_data_index_d,
    output logic [DATA_W-1:0]  raw_data_d,
`ifdef FSM_DISPATCH_STATS_EN
    output logic [15:0]        field_count,
    output logic [15:0]        stall_count,
`endif
    output logic               kind_err
);

    typedef enum logic [7:0] {
        ST_INIT       = 8'b0000_0001,
        ST_WAIT_DATA  = 8'b0000_0010,
        ST_V_PUSH     = 8'b0000_0100,
        ST_V_PUSH_INC = 8'b0000_1000,
        ST_R_PUSH     = 8'b0001_0000,
        ST_R_PUSH_INC = 8'b0010_0000,
        ST_DST_FULL   = 8'b0100_0000,
        ST_ERR        = 8'b1000_0000
    } state_t;

    state_t               state_q, state_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic                 field_open_q, field_open_d;
    logic                 cur_kind_q, cur_kind_d;

    logic                 w_kind;
    logic                 w_end;
    logic [DATA_W-1:0]    w_data;
    logic                 w_dst_full;
    state_t               w_push_state;
    logic                 w_pop;
    logic                 w_vpush;
    logic                 w_rpush;
    logic                 w_clr;
    logic                 w_kerr;

    assign w_kind     = in_fifo_q[DATA_W+1];
    assign w_end      = in_fifo_q[DATA_W];
    assign w_data     = in_fifo_q[DATA_W-1:0];
    assign w_dst_full = w_kind ? raw_data_fifo_full : varint_fifo_full;

    always_comb begin
        w_push_state = ST_V_PUSH;
        case ({w_kind, w_end})
            2'b00:   w_push_state = ST_V_PUSH;
            2'b01:   w_push_state = ST_V_PUSH_INC;
            2'b10:   w_push_state = ST_R_PUSH;
            default: w_push_state = ST_R_PUSH_INC;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        field_open_d = field_open_q;
        cur_kind_d   = cur_kind_q;
        w_pop        = 1'b0;
        w_vpush      = 1'b0;
        w_rpush      = 1'b0;
        w_clr        = 1'b0;
        w_kerr       = 1'b0;
        case (state_q)
            ST_INIT: begin
                w_clr        = 1'b1;
                index_d      = '0;
                field_open_d = 1'b0;
                cur_kind_d   = 1'b0;
                state_d      = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (!in_fifo_empty) begin
                    // A kind change inside an open field wins over back-pressure.
                    if (field_open_q && (w_kind != cur_kind_q)) begin
                        state_d = ST_ERR;
                    end else if (w_dst_full) begin
                        state_d = ST_DST_FULL;
                    end else begin
                        state_d = w_push_state;
                    end
                end
            end
            ST_V_PUSH, ST_V_PUSH_INC, ST_R_PUSH, ST_R_PUSH_INC: begin
                w_vpush      = (state_q == ST_V_PUSH) || (state_q == ST_V_PUSH_INC);
                w_rpush      = (state_q == ST_R_PUSH) || (state_q == ST_R_PUSH_INC);
                w_pop        = 1'b1;
                field_open_d = ~w_end;
                cur_kind_d   = w_kind;
                if ((state_q == ST_V_PUSH_INC) || (state_q == ST_R_PUSH_INC)) begin
                    index_d = index_q + INDEX_W'(1);
                end
                state_d = ST_WAIT_DATA;
            end
            ST_DST_FULL: begin
                // The held byte selects which FIFO we are waiting on.
                if (!w_dst_full) begin
                    state_d = w_push_state;
                end
            end
            ST_ERR: begin
                w_kerr  = 1'b1;
                state_d = ST_INIT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            index_q      <= '0;
            field_open_q <= 1'b0;
            cur_kind_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            field_open_q <= field_open_d;
            cur_kind_q   <= cur_kind_d;
        end
    end

    // Outputs are forced low while reset is held so INIT does not clear early.
    assign in_fifo_pop        = w_pop   & reset_n;
    assign varint_fifo_push   = w_vpush & reset_n;
    assign raw_data_fifo_push = w_rpush & reset_n;
    assign varint_fifo_clr    = w_clr   & reset_n;
    assign raw_data_fifo_clr  = w_clr   & reset_n;
    assign kind_err           = w_kerr  & reset_n;
    assign varint_index_d     = varint_fifo_push   ? index_q : '0;
    assign varint_data_d      = varint_fifo_push   ? w_data  : '0;
    assign raw_data_index_d   = raw_data_fifo_push ? index_q : '0;
    assign raw_data_d         = raw_data_fifo_push ? w_data  : '0;

`ifdef FSM_DISPATCH_STATS_EN
    logic [15:0] field_count_q, field_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        field_count_d = field_count_q;
        stall_count_d = stall_count_q;
        if (state_q == ST_INIT) begin
            field_count_d = '0;
            stall_count_d = '0;
        end else begin
            if (((state_q == ST_V_PUSH_INC) || (state_q == ST_R_PUSH_INC))
                && (field_count_q != 16'hFFFF)) begin
                field_count_d = field_count_q + 16'd1;
            end
            if ((state_q == ST_DST_FULL) && (stall_count_q != 16'hFFFF)) begin
                stall_count_d = stall_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            field_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            field_count_q <= field_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign field_count = field_count_q;
    assign stall_count = stall_count_q;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_dispatch
//  Purpose  : Directed self-checking bench for fsm_dispatch with a show-ahead
//             input FIFO model and push scoreboards.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_dispatch;

    logic        clk;
    logic        reset_n;
    logic        in_fifo_empty;
    logic [9:0]  in_fifo_q;
    logic        in_fifo_pop;
    logic        varint_fifo_full;
    logic        varint_fifo_clr;
    logic        varint_fifo_push;
    logic [9:0]  varint_index_d;
    logic [7:0]  varint_data_d;
    logic        raw_data_fifo_full;
    logic        raw_data_fifo_clr;
    logic        raw_data_fifo_push;
    logic [9:0]  raw_data_index_d;
    logic [7:0]  raw_data_d;
    logic        kind_err;
`ifdef FSM_DISPATCH_STATS_EN
    logic [15:0] field_count;
    logic [15:0] stall_count;
`endif

    fsm_dispatch #(.DATA_W(8), .INDEX_W(10)) u_dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .in_fifo_empty      (in_fifo_empty),
        .in_fifo_q          (in_fifo_q),
        .in_fifo_pop        (in_fifo_pop),
        .varint_fifo_full   (varint_fifo_full),
        .varint_fifo_clr    (varint_fifo_clr),
        .varint_fifo_push   (varint_fifo_push),
        .varint_index_d     (varint_index_d),
        .varint_data_d      (varint_data_d),
        .raw_data_fifo_full (raw_data_fifo_full),
        .raw_data_fifo_clr  (raw_data_fifo_clr),
        .raw_data_fifo_push (raw_data_fifo_push),
        .raw_data_index_d   (raw_data_index_d),
        .raw_data_d         (raw_data_d),
`ifdef FSM_DISPATCH_STATS_EN
        .field_count        (field_count),
        .stall_count        (stall_count),
`endif
        .kind_err           (kind_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]  fifo[$];
    logic [31:0] vq[$];
    logic [31:0] rq[$];
    logic        s_vpush, s_rpush, s_pop, s_vclr, s_rclr;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pop_cnt  = 0;
    int          kerr_cnt = 0;
    int          vclr_cnt = 0;
    int          viol     = 0;

    function automatic logic [31:0] ent(input logic [9:0] idx, input logic [7:0] d);
        return {14'b0, idx, d};
    endfunction

    function automatic logic [31:0] vpop();
        if (vq.size() == 0) return 32'hFFFF_FFFF;
        return vq.pop_front();
    endfunction

    function automatic logic [31:0] rpop();
        if (rq.size() == 0) return 32'hFFFF_FFFF;
        return rq.pop_front();
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic update_inputs();
        in_fifo_empty = (fifo.size() == 0);
        in_fifo_q     = in_fifo_empty ? 10'd0 : fifo[0];
    endtask

    // Sample outputs mid-cycle, then apply any pop just after the clock edge.
    task automatic tick();
        @(negedge clk);
        s_vpush = varint_fifo_push;
        s_rpush = raw_data_fifo_push;
        s_pop   = in_fifo_pop;
        s_vclr  = varint_fifo_clr;
        s_rclr  = raw_data_fifo_clr;
        if (s_vpush) vq.push_back(ent(varint_index_d, varint_data_d));
        if (s_rpush) rq.push_back(ent(raw_data_index_d, raw_data_d));
        if (s_pop) pop_cnt++;
        if (kind_err) kerr_cnt++;
        if (s_vclr) vclr_cnt++;
        if (((s_vpush | s_rpush) & (s_vclr | s_rclr)) | (s_vpush & s_rpush)) viol++;
        @(posedge clk);
        #1;
        if (s_pop && (fifo.size() > 0)) fifo.delete(0);
        update_inputs();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        update_inputs();
        while ((fifo.size() > 0) && (n < budget)) begin
            tick();
            n++;
        end
        check_eq("drain_timeout", fifo.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, c0, p0;
        reset_n            = 1'b0;
        varint_fifo_full   = 1'b0;
        raw_data_fifo_full = 1'b0;
        update_inputs();

        // Reset and the single INIT clear cycle
        repeat (3) tick();
        check_eq("rst_vclr", s_vclr, 0);
        check_eq("rst_rclr", s_rclr, 0);
        check_eq("rst_push_pop", {s_vpush, s_rpush, s_pop}, 0);
        reset_n = 1'b1;
        tick();
        check_eq("init_vclr", s_vclr, 1);
        check_eq("init_rclr", s_rclr, 1);
        check_eq("init_push", {s_vpush, s_rpush}, 0);
        tick();
        check_eq("wait_clr", {s_vclr, s_rclr}, 0);
        repeat (3) tick();
        check_eq("idle_pushes", vq.size() + rq.size(), 0);

        // Two-byte varint field followed by a raw field
        fifo.push_back({1'b0, 1'b0, 8'h81});
        fifo.push_back({1'b0, 1'b1, 8'h01});
        fifo.push_back({1'b1, 1'b1, 8'h55});
        drain(40);
        check_eq("t2_v0", vpop(), ent(10'd0, 8'h81));
        check_eq("t2_v1", vpop(), ent(10'd0, 8'h01));
        check_eq("t2_r0", rpop(), ent(10'd1, 8'h55));

        // Walk the index up to its last value, then check the wrap
        fifo.push_back({1'b0, 1'b1, 8'h0C});
        for (int i = 0; i < 1020; i++) fifo.push_back({2'b01, 8'(i)});
        drain(5000);
        check_eq("t2_idx2", vpop(), ent(10'd2, 8'h0C));
        vq.delete();
        fifo.push_back({1'b0, 1'b1, 8'hAA});
        fifo.push_back({1'b0, 1'b1, 8'hBB});
        drain(40);
        check_eq("t3_idx1023", vpop(), ent(10'd1023, 8'hAA));
        check_eq("t3_wrap0", vpop(), ent(10'd0, 8'hBB));

        // Raw back-pressure; varint full toggling must not matter
        raw_data_fifo_full = 1'b1;
        fifo.push_back({1'b1, 1'b1, 8'h33});
        update_inputs();
        p0 = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            varint_fifo_full = ~varint_fifo_full;
            tick();
        end
        check_eq("t4_no_pop", pop_cnt - p0, 0);
        check_eq("t4_no_push", rq.size() + vq.size(), 0);
        raw_data_fifo_full = 1'b0;
        varint_fifo_full   = 1'b0;
        tick();
        check_eq("t4_rel_hold", s_rpush, 0);
        tick();
        check_eq("t4_push_pop", {s_rpush, s_pop}, 2'b11);
`ifdef FSM_DISPATCH_STATS_EN
        check_eq("t4_stall_count", stall_count, 10);
`endif
        check_eq("t4_entry", rpop(), ent(10'd1, 8'h33));

        // Kind change inside an open varint field
        k0 = kerr_cnt;
        c0 = vclr_cnt;
        fifo.push_back({1'b0, 1'b0, 8'h11});
        fifo.push_back({1'b1, 1'b1, 8'h22});
        drain(40);
        check_eq("t5_kind_err", kerr_cnt - k0, 1);
        check_eq("t5_clr", vclr_cnt - c0, 1);
        check_eq("t5_v", vpop(), ent(10'd2, 8'h11));
        check_eq("t5_r_idx0", rpop(), ent(10'd0, 8'h22));
        check_eq("t5_r_extra", rq.size(), 0);

        // Reset while a raw push is in flight
        fifo.push_back({1'b1, 1'b1, 8'h44});
        update_inputs();
        tick();
        check_eq("t6_inflight", raw_data_fifo_push, 1);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_outs", {raw_data_fifo_push, in_fifo_pop, varint_fifo_clr,
                                 raw_data_fifo_clr, kind_err}, 0);
        check_eq("t6_rst_idx", raw_data_index_d, 0);
        tick();
        tick();
        check_eq("t6_not_popped", fifo.size(), 1);
        reset_n = 1'b1;
        drain(40);
        check_eq("t6_resent", rpop(), ent(10'd0, 8'h44));
        check_eq("t6_r_extra", rq.size() + vq.size(), 0);

        check_eq("protocol_viol", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
